param_cpu: RTL and testbench
============================

# param_cpu

Parametrised multicycle 8-bit CPU core with sixteen 8-bit registers, an 8-operation ALU with a flag register, conditional jumps, a HALT state and synchronous reset. Instructions are fetched over a single-port synchronous-read memory interface whose address width is a parameter. Debug and retire outputs expose internal state to the bench and to system-level glue.

## Interface
- ADDR_W, 8: program address width, legal range 8..16; jump targets are truncated to ADDR_W bits.
- RESET_PC, 0: pc value loaded on reset.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- mem_addr  out  ADDR_W  read address; combinational from the current state and pc
- mem_rd  out  1  read strobe; forced to 0 while reset is high
- mem_rdata  in  8  read data, valid exactly one cycle after the mem_rd cycle
- dbg_sel  in  4  register index for debug read
- dbg_data  out  8  combinational read of registers[dbg_sel]
- flags  out  4  {C,Z,S,V}
- halted  out  1  high while the core is in state HALT
- instr_done  out  1  one-cycle pulse on the final cycle of every instruction, HALT included

## Operation
- Opcode byte encoding is {hi[3:0], lo[3:0]}.
- One-byte instructions:
  - 0xFF NOP.
  - 0x7F HALT.
  - Any other opcode with lo=F or lo=E is a one-byte NOP.
- LD r,#imm: {r,C}, imm. r ← imm. Flags unchanged.
- LD r,r2: {r,8}, {x,r2}. r ← r2. Flags unchanged.
- ALU: {op,2}, {d,s}. d ← d op s.
  - op 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 CP.
  - CP is SUB that writes flags only.
  - op 8..F is a two-byte NOP.
- JP cc,addr: {cc,D}, hi, lo. If cc is true, pc ← {hi,lo}[ADDR_W-1:0].
  - cc codes: 0 never, 8 always, 6 Z, E !Z, 7 C, F !C. Any other code means never.
- Any other lo nibble is a two-byte NOP.
- Flag rules:
  - Z = (result == 0); S = result[7].
  - ADD/ADC: C = carry out, V = signed overflow.
  - SUB/SBC/CP: C = borrow; SBC subtracts the old C; V = signed overflow.
  - AND/OR/XOR: C unchanged, V = 0.
- State machine:
  - FETCH: mem_rd=1, mem_addr=pc, pc++ → DECODE.
  - DECODE: ir ← mem_rdata.
    - NOP → FETCH, with instr_done.
    - HALT → HALT, with instr_done.
    - Otherwise mem_rd=1, mem_addr=pc, pc++ → OPER1.
  - OPER1: data ← mem_rdata.
    - JP: mem_rd=1, mem_addr=pc, pc++ → OPER2.
    - Two-byte NOP → FETCH, with instr_done.
    - Otherwise → EXEC.
  - OPER2: evaluate cc against the current flags; load pc if true → FETCH, with instr_done.
  - EXEC: ALU result is written to the register and flags at the clock edge → FETCH, with instr_done.
  - HALT: terminal; mem_rd=0. Left only via reset.
- pc wraps modulo 2^ADDR_W on increment; all-ones+1 → 0.

## Timing
- Cycle counts from FETCH to FETCH:
  - NOP: 2 cycles.
  - LD and ALU: 4 cycles.
  - JP: 4 cycles, taken or not.
  - Two-byte NOP: 3 cycles.
- A register write in EXEC is visible to the next instruction's EXEC; there is no hazard.
- dbg_data reflects the write on the cycle after EXEC.
- Reset values:
  - state=FETCH, pc=RESET_PC, all registers 0, flags 0.
  - halted=0, instr_done=0, mem_rd=0 during reset.
- First fetch (mem_addr=RESET_PC) occurs on the first cycle with reset low.
- Reset asserted mid-instruction abandons the instruction: no register or flag write, no pc load.
- Reset wins over every state, including HALT.
- mem_rdata is sampled only in DECODE, OPER1 and OPER2; values on other cycles are ignored.

## Test plan
- Reset then program 0C 0A 1C 14 02 01 7F at address 0 → r0=30 (0x1E), r1=20, flags Z=0 C=0, halted=1 after 4+4+4+2=14 cycles, four instr_done pulses.
- LD r2,#0x80; LD r3,#0x80; ADD 23 → r2=0x00, C=1, Z=1, V=1, S=0; follow with ADC 23 (12 23) → r2=0x81, C=0.
- LD r4,#5; CP r4,r4 (72 44) → r4 still 5, Z=1; JP Z,0x0010 (6D 00 10) → next mem_addr=0x10; repeat with JP NZ → falls through to pc+3, still 4 cycles.
- ADDR_W=10: JP always 0xFFFF (8D FF FF) → pc=0x3FF; NOP at 0x3FF → next fetch address 0x000.
- Assert reset during EXEC of ADD r0,r1 → r0 and flags unchanged (0), next fetch at RESET_PC; assert reset while halted → halted=0 and fetching resumes.
- Undefined opcodes 0x05 0x99 then 0x8E → treated as two-byte NOP then one-byte NOP; no register or flag change; cycle counts 3 and 2.

Source files
------------

// File: rtl/param_cpu.sv
// Multicycle 8-bit CPU: sixteen registers, 8-op ALU with {C,Z,S,V} flags, conditional jumps
// and HALT, fetching one byte per memory access from a synchronous-read program store.
module param_cpu #(
  parameter int          ADDR_W   = 8,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic [3:0]        dbg_sel,
  output logic [7:0]        dbg_data,
  output logic [3:0]        flags,
  output logic              halted,
  output logic              instr_done
);

  typedef enum logic [2:0] {FETCH, DECODE, OPER1, OPER2, EXEC, HALT} cpuState_t;

  cpuState_t         state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [7:0]        ir, oper;
  logic [7:0]        regs [16];
  logic [3:0]        flagReg;
  logic [11:0]       aluOut;
  logic              memRd, done;

  // Returns {C,Z,S,V,result}; SUB/SBC/CP report borrow in C.
  function automatic logic [11:0] aluCalc(input logic [2:0] op, input logic signed [7:0] a,
                                          input logic signed [7:0] b, input logic [3:0] fl);
    logic [8:0]        wide;
    logic signed [7:0] r;
    logic              c, v;
    wide = '0;
    r    = '0;
    c    = fl[3];
    v    = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        wide = {1'b0, a} + {1'b0, b} + 9'((op == 3'd1) && fl[3]);
        r    = wide[7:0];
        c    = wide[8];
        v    = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd2, 3'd3, 3'd7: begin
        wide = {1'b0, a} - {1'b0, b} - 9'((op == 3'd3) && fl[3]);
        r    = wide[7:0];
        c    = wide[8];
        v    = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd4:    r = a & b;
      3'd5:    r = a | b;
      default: r = a ^ b;
    endcase
    return {c, (r == 8'sd0), r[7], v, r};
  endfunction

  function automatic logic ccTrue(input logic [3:0] cc, input logic [3:0] fl);
    case (cc)
      4'h8:    return 1'b1;
      4'h6:    return fl[2];
      4'hE:    return !fl[2];
      4'h7:    return fl[3];
      4'hF:    return !fl[3];
      default: return 1'b0;
    endcase
  endfunction

  // Only reached for opcodes that already consumed an operand byte.
  function automatic logic twoByteNop(input logic [7:0] op);
    if (op[3:0] == 4'h2) return op[7];
    return !((op[3:0] == 4'hC) || (op[3:0] == 4'h8) || (op[3:0] == 4'hD));
  endfunction

  assign aluOut     = aluCalc(ir[6:4], regs[oper[7:4]], regs[oper[3:0]], flagReg);
  assign mem_addr   = pc;
  assign mem_rd     = memRd & ~reset;
  assign instr_done = done & ~reset;
  assign halted     = (state == HALT) & ~reset;
  assign flags      = flagReg;
  assign dbg_data   = regs[dbg_sel];

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    memRd     = 1'b0;
    done      = 1'b0;
    case (state)
      FETCH: begin
        memRd     = 1'b1;
        pcNext    = pc + ADDR_W'(1);
        stateNext = DECODE;
      end
      DECODE: begin
        if (mem_rdata == 8'h7F) begin
          done      = 1'b1;
          stateNext = HALT;
        end else if ((mem_rdata[3:0] == 4'hF) || (mem_rdata[3:0] == 4'hE)) begin
          done      = 1'b1;
          stateNext = FETCH;
        end else begin
          memRd     = 1'b1;
          pcNext    = pc + ADDR_W'(1);
          stateNext = OPER1;
        end
      end
      OPER1: begin
        if (ir[3:0] == 4'hD) begin
          memRd     = 1'b1;
          pcNext    = pc + ADDR_W'(1);
          stateNext = OPER2;
        end else if (twoByteNop(ir)) begin
          done      = 1'b1;
          stateNext = FETCH;
        end else begin
          stateNext = EXEC;
        end
      end
      OPER2: begin
        done      = 1'b1;
        stateNext = FETCH;
        if (ccTrue(ir[7:4], flagReg)) pcNext = ADDR_W'({oper, mem_rdata});
      end
      EXEC: begin
        done      = 1'b1;
        stateNext = FETCH;
      end
      default: stateNext = HALT;
    endcase
  end

  // Control state: sequencer, pc, register file and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= ADDR_W'(RESET_PC);
      flagReg <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (state == EXEC) begin
        case (ir[3:0])
          4'hC: regs[ir[7:4]] <= oper;
          4'h8: regs[ir[7:4]] <= regs[oper[3:0]];
          default: begin
            if (ir[6:4] != 3'd7) regs[oper[7:4]] <= aluOut[7:0];
            flagReg <= aluOut[11:8];
          end
        endcase
      end
    end
  end

  // Instruction and operand latches capture the byte returned by the previous read
  always_ff @(posedge clk) begin
    if (state == DECODE) ir <= mem_rdata;
    if (state == OPER1) oper <= mem_rdata;
  end

endmodule

// File: tb/tb_param_cpu.sv
// Directed bench for param_cpu: small programs in a modelled synchronous-read memory,
// checking registers, flags, fetch addresses and instr_done timing.
module tb_param_cpu;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] memAddr;
  logic          memRd;
  logic [7:0]    memRdata;
  logic [3:0]    dbgSel;
  logic [7:0]    dbgData;
  logic [3:0]    flagsOut;
  logic          halted;
  logic          instrDone;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] prog [$];
  int         stamps [$];
  int         expStamps [$];
  int         cyc;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) if (memRd) memRdata <= mem[memAddr];

  param_cpu #(.ADDR_W(AW), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_addr(memAddr), .mem_rd(memRd), .mem_rdata(memRdata),
    .dbg_sel(dbgSel), .dbg_data(dbgData), .flags(flagsOut), .halted(halted),
    .instr_done(instrDone)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input string tag, input int r, input logic [7:0] exp);
    dbgSel = 4'(r);
    #1;
    check(tag, 16'(dbgData), 16'(exp));
  endtask

  // Advance whole cycles, logging the cycle number of every instr_done pulse
  task automatic step(input int n);
    repeat (n) begin
      cyc++;
      if (instrDone) stamps.push_back(cyc);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h7F;
  endtask

  task automatic loadProg(input int base);
    for (int i = 0; i < prog.size(); i++) mem[base + i] = prog[i];
  endtask

  task automatic release_();
    reset = 1'b0;
    cyc   = 0;
    stamps.delete();
    #1;
  endtask

  task automatic startCpu();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    release_();
  endtask

  task automatic runUntilHalt(input int maxC);
    while (!halted && cyc < maxC) step(1);
    check("halt_reached", 16'(halted), 16'd1);
  endtask

  task automatic checkStamps(input string tag);
    check({tag, "_pulses"}, 16'(stamps.size()), 16'(expStamps.size()));
    for (int i = 0; i < expStamps.size() && i < stamps.size(); i++)
      check({tag, "_stamp"}, 16'(stamps[i]), 16'(expStamps[i]));
  endtask

  initial begin
    reset  = 1'b1;
    dbgSel = 4'd0;
    cyc    = 0;
    clearMem();

    // Reset state, then LD/LD/ADD/HALT
    prog = '{8'h0C, 8'h0A, 8'h1C, 8'h14, 8'h02, 8'h01, 8'h7F};
    loadProg(0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_rd", 16'(memRd), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_done", 16'(instrDone), 16'd0);
    check("rst_flags", 16'(flagsOut), 16'd0);
    checkReg("rst_r0", 0, 8'h00);
    release_();
    check("first_addr", 16'(memAddr), 16'h000);
    check("first_rd", 16'(memRd), 16'd1);
    step(13);
    check("not_yet_halted", 16'(halted), 16'd0);
    runUntilHalt(40);
    check("p1_cycles", 16'(cyc), 16'd14);
    expStamps = '{4, 8, 12, 14};
    checkStamps("p1");
    checkReg("p1_r0", 0, 8'h1E);
    checkReg("p1_r1", 1, 8'h14);
    check("p1_flags", 16'(flagsOut), 16'h0);
    check("halt_no_rd", 16'(memRd), 16'd0);

    // Reset while halted
    reset = 1'b1;
    #1;
    check("halt_rst_halted", 16'(halted), 16'd0);
    startCpu();
    check("halt_rst_addr", 16'(memAddr), 16'h000);
    check("halt_rst_rd", 16'(memRd), 16'd1);
    check("halt_rst_halted2", 16'(halted), 16'd0);

    // Reset during EXEC of ADD r0,r1
    step(11);
    check("exec_done", 16'(instrDone), 16'd1);
    checkReg("exec_pre_r0", 0, 8'h0A);
    reset = 1'b1;
    #1;
    check("exec_rst_done", 16'(instrDone), 16'd0);
    @(posedge clk);
    #1;
    checkReg("exec_rst_r0", 0, 8'h00);
    check("exec_rst_flags", 16'(flagsOut), 16'h0);
    release_();
    check("exec_rst_addr", 16'(memAddr), 16'h000);
    runUntilHalt(40);
    check("exec_rerun_cycles", 16'(cyc), 16'd14);

    // ADD with carry/overflow, then ADC
    clearMem();
    prog = '{8'h2C, 8'h80, 8'h3C, 8'h80, 8'h02, 8'h23, 8'h7F};
    loadProg(0);
    startCpu();
    runUntilHalt(40);
    checkReg("add_r2", 2, 8'h00);
    checkReg("add_r3", 3, 8'h80);
    check("add_flags", 16'(flagsOut), 16'hD);
    clearMem();
    prog = '{8'h2C, 8'h80, 8'h3C, 8'h80, 8'h02, 8'h23, 8'h12, 8'h23, 8'h7F};
    loadProg(0);
    startCpu();
    runUntilHalt(40);
    checkReg("adc_r2", 2, 8'h81);
    check("adc_flags", 16'(flagsOut), 16'h2);

    // SUB borrow, LD r,r2, logic ops keep C, SBC uses it
    clearMem();
    prog = '{8'h2C, 8'h03, 8'h3C, 8'h05, 8'h22, 8'h23, 8'h68, 8'h02, 8'h42, 8'h63,
             8'h62, 8'h66, 8'h52, 8'h63, 8'h32, 8'h23, 8'h7F};
    loadProg(0);
    startCpu();
    runUntilHalt(80);
    checkReg("sbc_r2", 2, 8'hF8);
    checkReg("or_r6", 6, 8'h05);
    check("sbc_flags", 16'(flagsOut), 16'h2);

    // SUB signed overflow visible right after EXEC; CP leaves register alone
    clearMem();
    prog = '{8'h8C, 8'h80, 8'h9C, 8'h01, 8'h22, 8'h89, 8'h72, 8'h98, 8'h7F};
    loadProg(0);
    startCpu();
    step(12);
    check("subv_flags", 16'(flagsOut), 16'h1);
    checkReg("subv_r8", 8, 8'h7F);
    runUntilHalt(40);
    check("cp_flags", 16'(flagsOut), 16'hA);
    checkReg("cp_r9", 9, 8'h01);

    // CP then JP Z taken
    clearMem();
    prog = '{8'h4C, 8'h05, 8'h72, 8'h44, 8'h6D, 8'h00, 8'h10, 8'h7F};
    loadProg(0);
    prog = '{8'h5C, 8'h77, 8'h7F};
    loadProg(16);
    startCpu();
    step(12);
    check("jpz_addr", 16'(memAddr), 16'h010);
    check("jpz_cp_flags", 16'(flagsOut), 16'h4);
    runUntilHalt(40);
    checkReg("jpz_r4", 4, 8'h05);
    checkReg("jpz_r5", 5, 8'h77);
    expStamps = '{4, 8, 12, 16, 18};
    checkStamps("jpz");

    // JP NZ not taken falls through, same cycle count
    clearMem();
    prog = '{8'h4C, 8'h05, 8'h72, 8'h44, 8'hED, 8'h00, 8'h10, 8'h5C, 8'h66, 8'h7F};
    loadProg(0);
    prog = '{8'h5C, 8'h77, 8'h7F};
    loadProg(16);
    startCpu();
    step(12);
    check("jpnz_addr", 16'(memAddr), 16'h007);
    runUntilHalt(40);
    checkReg("jpnz_r5", 5, 8'h66);
    checkStamps("jpnz");

    // Jump target truncation and pc wrap with ADDR_W=10
    clearMem();
    prog = '{8'h8D, 8'hFF, 8'hFF};
    loadProg(0);
    mem[(1 << AW) - 1] = 8'hFF;
    startCpu();
    step(4);
    check("wrap_jp_addr", 16'(memAddr), 16'h3FF);
    step(1);
    check("wrap_nop_done", 16'(instrDone), 16'd1);
    step(1);
    check("wrap_addr", 16'(memAddr), 16'h000);

    // Undefined opcodes: two-byte NOP, one-byte NOP, ALU op >= 8
    clearMem();
    prog = '{8'h0C, 8'h11, 8'h05, 8'h99, 8'h8E, 8'hA2, 8'h01, 8'h7F};
    loadProg(0);
    startCpu();
    runUntilHalt(40);
    check("undef_cycles", 16'(cyc), 16'd14);
    expStamps = '{4, 7, 9, 12, 14};
    checkStamps("undef");
    checkReg("undef_r0", 0, 8'h11);
    checkReg("undef_r9", 9, 8'h00);
    checkReg("undef_r1", 1, 8'h00);
    check("undef_flags", 16'(flagsOut), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
